// File: rtl/frame_sched_pkg.sv
// Shared definitions for the frame read scheduler and the frame mux:
// FSM encoding, one-hot FIFO select constants and an index-to-one-hot helper.
package frame_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        SELECT = 2'd2,
        VALID  = 2'd3
    } sched_state_t;

    localparam int SW_MAX   = 32;
    localparam int SW_IDX_W = 5;

    localparam logic [4:0] FIFO_SW_0 = 5'b00001;
    localparam logic [4:0] FIFO_SW_1 = 5'b00010;
    localparam logic [4:0] FIFO_SW_2 = 5'b00100;
    localparam logic [4:0] FIFO_SW_3 = 5'b01000;
    localparam logic [4:0] FIFO_SW_4 = 5'b10000;

    // Callers size-cast the result down to their own select width.
    function automatic logic [SW_MAX-1:0] sw_onehot(
        input logic [SW_IDX_W-1:0] idx
    );
        logic [SW_MAX-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/rr_next_grant.sv
// Combinational round-robin picker: first set req bit after ptr, wrapping,
// with ptr itself searched last.
module rr_next_grant #(
    parameter int NUM_SW_INST = 5,
    parameter int ID_W        = 3
) (
    input  logic [NUM_SW_INST-1:0] req,
    input  logic [ID_W-1:0]        ptr,
    output logic [ID_W-1:0]        pick,
    output logic                   found
);

    // Walk the search order backwards so the nearest hit is assigned last.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int k = NUM_SW_INST; k >= 1; k--) begin
            int s;
            s = int'(ptr) + k;
            if (s >= NUM_SW_INST) begin
                s = s - NUM_SW_INST;
            end
            if (req[s]) begin
                pick  = ID_W'(s);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_rd_sched.sv
// Round-robin read scheduler feeding the registered frame mux: read pulse,
// then mux select, then frame_valid, one frame per three cycles at best.
module frame_rd_sched
    import frame_sched_pkg::*;
#(
    parameter  int NUM_SW_INST = 5,
    parameter  int CNT_WIDTH   = 16,
    localparam int ID_W        = (NUM_SW_INST > 1) ? $clog2(NUM_SW_INST) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_SW_INST-1:0] fifo_empty,
    input  logic                   out_ready,
    output logic [NUM_SW_INST-1:0] fifo_rd,
    output logic [NUM_SW_INST-1:0] rd_sel,
    output logic                   frame_valid,
    output logic [ID_W-1:0]        grant_id,
    output logic                   busy,
    output logic [CNT_WIDTH-1:0]   frame_cnt
);

    sched_state_t state, state_n;

    logic [ID_W-1:0]        rr_ptr, rr_ptr_n;
    logic [ID_W-1:0]        pick;
    logic                   found;
    logic                   launch;
    logic [NUM_SW_INST-1:0] req;
    logic [NUM_SW_INST-1:0] fifo_rd_n;
    logic [NUM_SW_INST-1:0] rd_sel_n;
    logic                   frame_valid_n;
    logic [ID_W-1:0]        grant_id_n;
    logic                   busy_n;
    logic [CNT_WIDTH-1:0]   frame_cnt_n;

    assign req    = ~fifo_empty;
    assign launch = out_ready && found;

    rr_next_grant #(
        .NUM_SW_INST (NUM_SW_INST),
        .ID_W        (ID_W)
    ) u_rr (
        .req   (req),
        .ptr   (rr_ptr),
        .pick  (pick),
        .found (found)
    );

    always_comb begin
        state_n       = state;
        fifo_rd_n     = '0;
        rd_sel_n      = '0;
        frame_valid_n = 1'b0;
        grant_id_n    = grant_id;
        rr_ptr_n      = rr_ptr;
        frame_cnt_n   = frame_cnt;

        unique case (state)
            IDLE, VALID: begin
                // VALID re-arbitrates exactly like IDLE for back-to-back frames.
                if (launch) begin
                    state_n     = READ;
                    fifo_rd_n   = NUM_SW_INST'(sw_onehot(SW_IDX_W'(pick)));
                    grant_id_n  = pick;
                    rr_ptr_n    = pick;
                    frame_cnt_n = frame_cnt + CNT_WIDTH'(1);
                end else begin
                    state_n = IDLE;
                end
            end
            READ: begin
                state_n  = SELECT;
                rd_sel_n = NUM_SW_INST'(sw_onehot(SW_IDX_W'(grant_id)));
            end
            SELECT: begin
                state_n       = VALID;
                frame_valid_n = 1'b1;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            fifo_rd     <= '0;
            rd_sel      <= '0;
            frame_valid <= 1'b0;
            grant_id    <= '0;
            busy        <= 1'b0;
            frame_cnt   <= '0;
            rr_ptr      <= ID_W'(NUM_SW_INST - 1);
        end else begin
            state       <= state_n;
            fifo_rd     <= fifo_rd_n;
            rd_sel      <= rd_sel_n;
            frame_valid <= frame_valid_n;
            grant_id    <= grant_id_n;
            busy        <= busy_n;
            frame_cnt   <= frame_cnt_n;
            rr_ptr      <= rr_ptr_n;
        end
    end

endmodule

// File: tb/tb_frame_rd_sched.sv
// Directed bench for frame_rd_sched with a small FIFO and registered mux model.
module tb_frame_rd_sched;
    import frame_sched_pkg::*;

    logic        clk;
    logic        rst;
    logic [4:0]  fifo_empty;
    logic        out_ready;
    logic [4:0]  fifo_rd;
    logic [4:0]  rd_sel;
    logic        frame_valid;
    logic [2:0]  grant_id;
    logic        busy;
    logic [15:0] frame_cnt;

    logic [31:0] fifo_dout [5];
    logic [31:0] frame_out;

    int n_chk  = 0;
    int n_fail = 0;

    frame_rd_sched #(
        .NUM_SW_INST (5),
        .CNT_WIDTH   (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fifo_empty  (fifo_empty),
        .out_ready   (out_ready),
        .fifo_rd     (fifo_rd),
        .rd_sel      (rd_sel),
        .frame_valid (frame_valid),
        .grant_id    (grant_id),
        .busy        (busy),
        .frame_cnt   (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO i presents 0xCAFE000i one cycle after its read pulse.
    always @(posedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (fifo_rd[i]) fifo_dout[i] <= 32'hCAFE0000 | i;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (rd_sel[i]) frame_out <= fifo_dout[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        chk("inv_excl", 32'((fifo_rd != 0) && (rd_sel != 0)), 32'd0);
        chk("inv_oh", 32'($onehot0(fifo_rd) && $onehot0(rd_sel)), 32'd1);
    end

    initial begin
        rst        = 1'b1;
        fifo_empty = 5'b11111;
        out_ready  = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("rst_fifo_rd", 32'(fifo_rd), 32'd0);
        chk("rst_rd_sel", 32'(rd_sel), 32'd0);
        chk("rst_fv", 32'(frame_valid), 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt", 32'(frame_cnt), 32'd0);
        rst = 1'b0;
        tick();
        tick();
        chk("empty_busy", 32'(busy), 32'd0);
        chk("empty_cnt", 32'(frame_cnt), 32'd0);

        // Single FIFO 2
        fifo_empty = 5'b11011;
        tick();
        chk("s_fifo_rd", 32'(fifo_rd), 32'(FIFO_SW_2));
        chk("s_gid", 32'(grant_id), 32'd2);
        chk("s_cnt", 32'(frame_cnt), 32'd1);
        chk("s_busy", 32'(busy), 32'd1);
        fifo_empty = 5'b11111;
        tick();
        chk("s_rd_sel", 32'(rd_sel), 32'(FIFO_SW_2));
        chk("s_rd_off", 32'(fifo_rd), 32'd0);
        tick();
        chk("s_fv", 32'(frame_valid), 32'd1);
        chk("s_frame", frame_out, 32'hCAFE0002);
        chk("s_sel_off", 32'(rd_sel), 32'd0);
        tick();
        chk("s_fv_off", 32'(frame_valid), 32'd0);
        chk("s_idle", 32'(busy), 32'd0);

        // Full round robin from reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fifo_empty = 5'b00000;
        for (int g = 0; g < 10; g++) begin
            tick();
            chk("rr_fifo_rd", 32'(fifo_rd), 32'd1 << (g % 5));
            chk("rr_gid", 32'(grant_id), 32'(g % 5));
            chk("rr_cnt", 32'(frame_cnt), 32'(g + 1));
            tick();
            chk("rr_rd_sel", 32'(rd_sel), 32'd1 << (g % 5));
            tick();
            chk("rr_fv", 32'(frame_valid), 32'd1);
            chk("rr_frame", frame_out, 32'hCAFE0000 | (g % 5));
        end
        chk("rr_cnt10", 32'(frame_cnt), 32'd10);

        // Serve 3, then 1 and 3 pending: 1 wins, then 3
        fifo_empty = 5'b10111;
        tick();
        chk("p3_fifo_rd", 32'(fifo_rd), 32'(FIFO_SW_3));
        chk("p3_gid", 32'(grant_id), 32'd3);
        fifo_empty = 5'b10101;
        tick();
        tick();
        tick();
        chk("p1_fifo_rd", 32'(fifo_rd), 32'(FIFO_SW_1));
        chk("p1_gid", 32'(grant_id), 32'd1);
        chk("p1_cnt", 32'(frame_cnt), 32'd12);
        fifo_empty = 5'b10111;
        tick();
        tick();
        tick();
        chk("p3b_fifo_rd", 32'(fifo_rd), 32'(FIFO_SW_3));
        chk("p3b_cnt", 32'(frame_cnt), 32'd13);

        // out_ready low while a frame is in flight
        out_ready = 1'b0;
        tick();
        tick();
        chk("or_fv", 32'(frame_valid), 32'd1);
        chk("or_frame", frame_out, 32'hCAFE0003);
        tick();
        chk("or_fv_off", 32'(frame_valid), 32'd0);
        chk("or_idle", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("or_hold_rd", 32'(fifo_rd), 32'd0);
            chk("or_hold_busy", 32'(busy), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        chk("or_resume", 32'(fifo_rd), 32'(FIFO_SW_3));
        chk("or_cnt", 32'(frame_cnt), 32'd14);

        // Reset mid-SELECT
        tick();
        chk("ab_rd_sel", 32'(rd_sel), 32'(FIFO_SW_3));
        #2;
        rst = 1'b1;
        #1;
        chk("ab_sel_clr", 32'(rd_sel), 32'd0);
        chk("ab_busy_clr", 32'(busy), 32'd0);
        chk("ab_cnt_clr", 32'(frame_cnt), 32'd0);
        fifo_empty = 5'b10101;
        tick();
        chk("ab_no_fv", 32'(frame_valid), 32'd0);
        rst = 1'b0;
        tick();
        chk("ab_first_rd", 32'(fifo_rd), 32'(FIFO_SW_1));
        chk("ab_first_gid", 32'(grant_id), 32'd1);
        chk("ab_first_cnt", 32'(frame_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_rd_sched.md
Name: frame_rd_sched

Overview:
- Round-robin read scheduler sitting directly upstream of the frame mux.
- Watches the empty flags of the NUM_SW_INST switch FIFOs and picks one non-empty FIFO per frame.
- Pulses that FIFO's read enable, then drives the one-hot rd_sel so the registered mux captures the FIFO output.
- Flags the cycle in which the mux's frame_out holds a valid frame.

Parameters:
- NUM_SW_INST, 5, number of switch FIFOs (the mux's one-hot select width).
- CNT_WIDTH, 16, width of the granted-frame counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- fifo_empty  input  NUM_SW_INST  per-FIFO empty flag; bit i=1 means FIFO i has no frame.
- out_ready  input  1  downstream can accept a frame; sampled only in IDLE and VALID.
- fifo_rd  output  NUM_SW_INST  one-hot read-enable pulse to FIFOs; FIFO data is valid 1 cycle after the pulse.
- rd_sel  output  NUM_SW_INST  one-hot select to the frame mux; all-zero when not selecting.
- frame_valid  output  1  high exactly in the cycle the mux frame_out carries the granted frame.
- grant_id  output  $clog2(NUM_SW_INST)  index of the current/last granted FIFO.
- busy  output  1  high in READ, SELECT and VALID.
- frame_cnt  output  CNT_WIDTH  number of frames granted since reset; wraps modulo 2^CNT_WIDTH.

Behaviour:
- All outputs are registered.
- Reset values: fifo_rd=0, rd_sel=0, frame_valid=0, grant_id=0, busy=0, frame_cnt=0, state=IDLE, rr_ptr=NUM_SW_INST-1 (so port 0 wins first).
- Asserting rst mid-operation aborts immediately, with no completion of the pending frame. Any FIFO already read has its frame dropped, which is acceptable.
- Request vector: req = ~fifo_empty.
- Pick rule: the first set bit of req searching indices rr_ptr+1, rr_ptr+2, ... wrapping modulo NUM_SW_INST. rr_ptr itself is searched last.
- FSM states:
  - IDLE: if out_ready && |req, then go to READ. On that edge: fifo_rd <= onehot(pick), grant_id <= pick, rr_ptr <= pick, frame_cnt++. Otherwise stay in IDLE with all pulses 0.
  - READ (1 cycle): fifo_rd high. On the edge to SELECT: fifo_rd <= 0, rd_sel <= onehot(grant_id).
  - SELECT (1 cycle): rd_sel high; the mux registers FIFO data at the end of this cycle. On the edge to VALID: rd_sel <= 0, frame_valid <= 1.
  - VALID (1 cycle): frame_valid high. Exit is evaluated exactly as in IDLE:
    - out_ready && |req → READ (back-to-back, one frame per 3 cycles);
    - else → IDLE.
    - frame_valid <= 0 on exit.
- Latency: fifo_rd pulse at cycle T, rd_sel high at T+1, frame_valid (and valid mux frame_out) at T+2.
- fifo_empty is ignored outside IDLE/VALID. A FIFO cannot drain without a read, so the grant stays valid.
- Simultaneous requests: round-robin order only, no fixed priority. A FIFO that stays non-empty is served at least once every NUM_SW_INST grants.
- out_ready low in VALID does not cancel frame_valid; it only blocks the next grant.
- Invariants: fifo_rd and rd_sel are never both non-zero, and each is zero or one-hot at all times.
- NUM_SW_INST=1: rr_ptr is constant and the pick is always 0.

Decomposition:
- Package frame_sched_pkg holds:
  - the state encoding (IDLE, READ, SELECT, VALID);
  - the one-hot FIFO constants FIFO_SW_0..FIFO_SW_4 shared with the mux;
  - a helper function for index-to-one-hot.
- Sub-module rr_next_grant: purely combinational.
  - Inputs: req[NUM_SW_INST], ptr.
  - Outputs: pick index and a found flag.
  - Unit-testable on its own.

Test Plan:
- Reset with fifo_empty=5'b11111 and out_ready=1 for 10 cycles → all outputs 0, state stays IDLE, frame_cnt=0.
- fifo_empty=5'b11011 (only FIFO 2 non-empty), out_ready=1, FIFO 2 holding 0xCAFE0002 → fifo_rd=5'b00100 at T, rd_sel=5'b00100 at T+1, frame_valid=1 with mux frame_out=0xCAFE0002 at T+2, grant_id=2, frame_cnt=1.
- All FIFOs non-empty, out_ready held 1 for 30 cycles → grants in order 0,1,2,3,4,0,... at 3-cycle spacing; frame_cnt=10 after cycle 30.
- FIFOs 1 and 3 non-empty, rr_ptr=3 after serving 3 → next grant goes to 1, not 3. Then with only 3 still non-empty, the following grant goes to 3.
- out_ready dropped during VALID → frame_valid still pulses, next state IDLE. Raising out_ready 4 cycles later → fifo_rd pulse on the following cycle.
- rst asserted during SELECT → rd_sel and busy clear asynchronously with no frame_valid pulse. After release, the first grant goes to the lowest non-empty index.
